// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : ahb_sram_slave
// Description : AHB-Lite word-organised SRAM responder with programmable
//               wait states and the two-cycle ERROR response.
//
// Ports
//   clk        in   1           system clock
//   rst        in   1           synchronous active-high reset
//   hsel       in   1           slave select from the fabric
//   haddr      in   ADDR_WIDTH  transfer byte address
//   htrans     in   2           IDLE/BUSY/NONSEQ/SEQ
//   hwrite     in   1           1 = write
//   hsize      in   3           0 byte, 1 half, 2 word
//   hburst     in   3           not used for decoding; every beat stands alone
//   hwdata     in   DATA_WIDTH  write data (data phase)
//   hready     in   1           bus-level ready
//   hreadyout  out  1           this slave's ready
//   hresp      out  2           00 OKAY, 01 ERROR
//   hrdata     out  DATA_WIDTH  read data (non-zero only in a read DATA cycle)
//
// Optional feature macro: AHB_SRAM_RO_REGION_EN
//   When defined, writes to word indices below RO_WORDS take the ERROR
//   response and leave memory untouched.
//
// Revision    : 1.0  initial release
// ============================================================================
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0,
    parameter int RO_WORDS    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic [1:0]            hresp,
    output logic [DATA_WIDTH-1:0] hrdata
);

    localparam int c_idx_w = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_wait = 3'd1;
    localparam logic [2:0] c_st_data = 3'd2;
    localparam logic [2:0] c_st_err1 = 3'd3;
    localparam logic [2:0] c_st_err2 = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] c_depth     = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [3:0]            c_wait_load = 4'(WAIT_STATES);

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [2:0]            w_accept_state;
    logic [3:0]            r_cnt;

    logic [c_idx_w-1:0]    r_idx;
    logic [1:0]            r_lane;
    logic [2:0]            r_size;
    logic                  r_write;

    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_word;
    logic                  w_size_err;
    logic                  w_align_err;
    logic                  w_range_err;
    logic                  w_ro_err;
    logic                  w_err;
    logic [3:0]            w_be;
    logic                  w_unused_ro;
    logic                  w_unused_bits;

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    // hreadyout is high exactly in the states that can end a data phase,
    // so it doubles as the "may accept a new address phase" qualifier.
    assign w_accept    = hsel & hready & htrans[1] & hreadyout;
    assign w_word      = haddr >> 2;
    assign w_size_err  = (hsize > 3'd2);
    assign w_align_err = ((hsize == 3'd1) && haddr[0]) ||
                         ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
    assign w_range_err = (w_word >= c_depth);

`ifdef AHB_SRAM_RO_REGION_EN
    localparam logic [ADDR_WIDTH-1:0] c_ro_words = ADDR_WIDTH'(RO_WORDS);
    assign w_ro_err    = hwrite && (w_word < c_ro_words);
    assign w_unused_ro = 1'b0;
`else
    assign w_ro_err    = 1'b0;
    assign w_unused_ro = (RO_WORDS != 0);
`endif

    assign w_err = w_size_err | w_align_err | w_range_err | w_ro_err;

    // Burst type carries no meaning for a beat-by-beat responder.
    assign w_unused_bits = ^{hburst, w_unused_ro};

    // ------------------------------------------------------------------
    // FSM: state register and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            if (w_accept && !w_err) begin
                r_cnt <= c_wait_load;
            end else if (r_state == c_st_wait) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_accept_state = w_err ? c_st_err1
                       : ((WAIT_STATES > 0) ? c_st_wait : c_st_data);
        w_next_state   = c_st_idle;
        case (r_state)
            c_st_idle,
            c_st_data,
            c_st_err2: w_next_state = w_accept ? w_accept_state : c_st_idle;
            // Counter value 1 marks the last low-ready cycle.
            c_st_wait: w_next_state = (r_cnt <= 4'd1) ? c_st_data : c_st_wait;
            c_st_err1: w_next_state = c_st_err2;
            default:   w_next_state = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        hreadyout = 1'b1;
        hresp     = 2'b00;
        hrdata    = '0;
        case (r_state)
            c_st_wait: hreadyout = 1'b0;
            c_st_data: begin
                if (!r_write) begin
                    hrdata = r_mem[r_idx];
                end
            end
            c_st_err1: begin
                hreadyout = 1'b0;
                hresp     = 2'b01;
            end
            c_st_err2: hresp = 2'b01;
            default: begin
                hreadyout = 1'b1;
                hresp     = 2'b00;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address-phase capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_lane  <= 2'b00;
            r_size  <= 3'd0;
            r_write <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= haddr[c_idx_w+1:2];
            r_lane  <= haddr[1:0];
            r_size  <= hsize;
            r_write <= hwrite;
        end
    end

    // ------------------------------------------------------------------
    // Little-endian byte enables for the latched transfer
    // ------------------------------------------------------------------
    always_comb begin
        w_be = 4'b0000;
        case (r_size)
            3'd0:    w_be = 4'b0001 << r_lane;
            3'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
            3'd2:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // Memory is never cleared; a write pending when rst rises is dropped.
    // Errored transfers never reach DATA, so they cannot write.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == c_st_data) && r_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[r_idx][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
